image_window_buffer: RTL and testbench
======================================

// Module: image_window_buffer
// PURPOSE
//   Parametrised, double-buffered (ping-pong) image row store for the image coprocessor.
//   The loader writes one full image into the fill bank while the filter engine reads
//   the other bank, one 3-row vertical window (row r-1, r, r+1) per request.
//   A wr_done/rd_done handshake hands banks over, so the loader and filter never collide.
//   Row edges are handled by the programmable edge mode.
// PARAMETERS
//   DATA_W    3072  bits per image row (128 pixels x 24b RGB)
//   ROWS      128   rows per image, >= 3
//   ADDR_W    7     row address width, = $clog2(ROWS)
//   EDGE_MODE 0     0: out-of-image window rows read as zero; 1: replicate edge row
// PORTS
//   clk         in   1       clock, all state on rising edge
//   rst_n       in   1       async active-low reset
//   we          in   1       write row wdata to fill bank at waddr
//   waddr       in   ADDR_W  write row address
//   wdata       in   DATA_W  write row data
//   wr_done     in   1       pulse: fill bank holds a complete image
//   wr_ready    out  1       fill bank accepts writes (= ~fill_full)
//   re          in   1       read request for window centred on raddr
//   raddr       in   ADDR_W  centre row of the window
//   rd_done     in   1       pulse: consumer finished with read bank
//   img_valid   out  1       read bank holds an unconsumed image
//   rvalid      out  1       rdata_* valid (1 cycle after accepted re)
//   rdata_top   out  DATA_W  row raddr-1 (edge-handled)
//   rdata_mid   out  DATA_W  row raddr
//   rdata_bot   out  DATA_W  row raddr+1 (edge-handled)
//   rd_bank     out  1       index of current read bank (debug)
//   wr_overrun  out  1       sticky: write attempted while wr_ready=0
// BEHAVIOUR
//   Reset:
//     - wr_sel=0, rd_bank=1, fill_full=0, img_valid=0, rvalid=0.
//     - rdata_* = 0, wr_overrun=0; memory contents undefined.
//   Mid-operation reset discards both images.
//   Write path:
//     - we && wr_ready: mem[wr_sel][waddr] <= wdata.
//     - we && !wr_ready: write dropped and wr_overrun <= 1 (cleared only by reset).
//     - waddr >= ROWS: write dropped and wr_overrun <= 1.
//   wr_done && wr_ready sets fill_full. wr_done while fill_full is ignored.
//   rd_done clears img_valid. rd_done while !img_valid is ignored.
//   Swap:
//     - Occurs on any edge where the registered fill_full=1 && img_valid=0.
//     - wr_sel flips, rd_bank flips, img_valid <= 1, fill_full <= 0.
//     - Same-edge wr_done/rd_done only update flags; the swap happens next cycle at earliest.
//   Read path: re accepted only when img_valid=1. re while !img_valid is ignored (rvalid=0).
//     - Accepted re latches mem[rd_bank] rows, 1-cycle latency: rvalid=1 on the next cycle.
//     - rdata_* hold their last value when rvalid=0. Back-to-back re gives one window per cycle.
//     - raddr=0: rdata_top = 0 (EDGE_MODE 0) or row 0 (EDGE_MODE 1).
//     - raddr=ROWS-1: rdata_bot = 0 or row ROWS-1, same rule.
//     - raddr >= ROWS: all three rows return 0 with rvalid=1.
//   Simultaneous events:
//     - re and rd_done on the same edge: the read is served from the pre-release bank.
//     - re and swap on the same edge: the read uses the pre-swap rd_bank.
//     - Write and read always target different banks, so there is no same-address hazard.
// TESTING
//   1 Reset -> wr_ready=1, img_valid=0, rvalid=0, rd_bank=1, rdata_*=0.
//   2 Write rows 0..127 with pattern {96{32'(k+1)}}, then wr_done.
//       -> wr_ready=0; 2 cycles later img_valid=1, rd_bank=0, wr_ready=1.
//   3 re, raddr=5 -> next cycle rvalid=1, rows carry patterns 5/6/7.
//       raddr=0 -> top=0, mid=pat 1, bot=pat 2 (EDGE_MODE 0); with EDGE_MODE=1, top=pat 1.
//   4 Fill the second image, then wr_done while img_valid=1 -> no swap, wr_ready=0.
//       A write now sets wr_overrun=1. After rd_done -> next cycle the swap happens, rd_bank=1.
//   5 re with raddr=10 on the same edge as rd_done -> window from old bank (pats 10/11/12).
//       The following re is ignored, rvalid=0.
//   6 Assert rst_n low during a back-to-back read burst -> all flags and outputs return to reset values.

Source files
------------

// File: rtl/image_window_buffer.sv
// Ping-pong image row store: the loader fills one bank while the filter reads
// 3-row vertical windows from the other; wr_done/rd_done hand the banks over.
module image_window_buffer #(
    parameter int DATA_W    = 3072,
    parameter int ROWS      = 128,
    parameter int ADDR_W    = $clog2(ROWS),
    parameter int EDGE_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wr_done,
    output logic              wr_ready,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              rd_done,
    output logic              img_valid,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata_top,
    output logic [DATA_W-1:0] rdata_mid,
    output logic [DATA_W-1:0] rdata_bot,
    output logic              rd_bank,
    output logic              wr_overrun
);

    localparam logic [ADDR_W:0]   ROWS_X = (ADDR_W+1)'(ROWS);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    logic [DATA_W-1:0] mem [2][ROWS];
    logic              wr_sel;
    logic              fill_full;
    logic              waddr_ok, raddr_ok, wr_en, rd_acc, swap;
    logic [DATA_W-1:0] top_n, mid_n, bot_n;

    // The read bank is always the one the loader is not filling.
    assign rd_bank  = ~wr_sel;
    assign wr_ready = ~fill_full;
    assign waddr_ok = {1'b0, waddr} < ROWS_X;
    assign raddr_ok = {1'b0, raddr} < ROWS_X;
    assign wr_en    = we & wr_ready & waddr_ok;
    assign rd_acc   = re & img_valid;
    assign swap     = fill_full & ~img_valid;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_sel][waddr] <= wdata;
    end

    always_comb begin
        top_n = '0;
        mid_n = '0;
        bot_n = '0;
        if (raddr_ok) begin
            mid_n = mem[rd_bank][raddr];
            if (raddr != '0)
                top_n = mem[rd_bank][raddr - ONE];
            else if (EDGE_MODE != 0)
                top_n = mem[rd_bank][0];
            if (raddr != LAST)
                bot_n = mem[rd_bank][raddr + ONE];
            else if (EDGE_MODE != 0)
                bot_n = mem[rd_bank][ROWS-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel     <= 1'b0;
            fill_full  <= 1'b0;
            img_valid  <= 1'b0;
            rvalid     <= 1'b0;
            rdata_top  <= '0;
            rdata_mid  <= '0;
            rdata_bot  <= '0;
            wr_overrun <= 1'b0;
        end else begin
            if (we && !(wr_ready && waddr_ok))
                wr_overrun <= 1'b1;
            rvalid <= rd_acc;
            if (rd_acc) begin
                rdata_top <= top_n;
                rdata_mid <= mid_n;
                rdata_bot <= bot_n;
            end
            // A swap needs fill_full=1 and img_valid=0, so wr_done/rd_done
            // are both no-ops on a swap edge.
            if (swap) begin
                wr_sel    <= ~wr_sel;
                img_valid <= 1'b1;
                fill_full <= 1'b0;
            end else begin
                if (wr_done && !fill_full)
                    fill_full <= 1'b1;
                if (rd_done && img_valid)
                    img_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_image_window_buffer.sv
// Bench for image_window_buffer: both edge modes driven side by side and checked
// every cycle against a bank-level reference model, plus directed corner sequences.
module tb_image_window_buffer;

    localparam int DW   = 3072;
    localparam int ROWS = 128;
    localparam int AW   = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          we, wr_done, re, rd_done;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata;

    logic          wr_ready [2];
    logic          img_valid [2];
    logic          rvalid [2];
    logic          rd_bank [2];
    logic          wr_overrun [2];
    logic [DW-1:0] rtop [2];
    logic [DW-1:0] rmid [2];
    logic [DW-1:0] rbot [2];

    image_window_buffer #(.DATA_W(DW), .ROWS(ROWS), .ADDR_W(AW), .EDGE_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .wr_done(wr_done), .wr_ready(wr_ready[0]), .re(re), .raddr(raddr),
        .rd_done(rd_done), .img_valid(img_valid[0]), .rvalid(rvalid[0]),
        .rdata_top(rtop[0]), .rdata_mid(rmid[0]), .rdata_bot(rbot[0]),
        .rd_bank(rd_bank[0]), .wr_overrun(wr_overrun[0])
    );

    image_window_buffer #(.DATA_W(DW), .ROWS(ROWS), .ADDR_W(AW), .EDGE_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .wr_done(wr_done), .wr_ready(wr_ready[1]), .re(re), .raddr(raddr),
        .rd_done(rd_done), .img_valid(img_valid[1]), .rvalid(rvalid[1]),
        .rdata_top(rtop[1]), .rdata_mid(rmid[1]), .rdata_bot(rbot[1]),
        .rd_bank(rd_bank[1]), .wr_overrun(wr_overrun[1])
    );

    // Reference model: two physical banks, the index of the bank being filled,
    // and the handshake flags, updated from the rules at each clock edge.
    logic [DW-1:0] rm [2][ROWS];
    int            m_sel;
    bit            m_full, m_valid, m_rvalid, m_ovr;
    logic [DW-1:0] m_top [2];
    logic [DW-1:0] m_bot [2];
    logic [DW-1:0] m_mid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [AW-1:0] raddr;
        int t0, m, b0, t1, b1;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [DW-1:0] pat(int p);
        logic [DW-1:0] r;
        r = '0;
        if (p != 0)
            for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = p;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_row();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [31:0] fold(logic [DW-1:0] v);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < DW/32; i++) s = s ^ v[i*32 +: 32];
        return s;
    endfunction

    function automatic logic [DW-1:0] row_at(int b, int a, int em);
        if (a < 0)     return (em != 0) ? rm[b][0] : '0;
        if (a >= ROWS) return (em != 0) ? rm[b][ROWS-1] : '0;
        return rm[b][a];
    endfunction

    task automatic model_reset();
        m_sel = 0; m_full = 0; m_valid = 0; m_rvalid = 0; m_ovr = 0;
        m_mid = '0;
        for (int e = 0; e < 2; e++) begin m_top[e] = '0; m_bot[e] = '0; end
    endtask

    task automatic model_edge();
        bit sw;
        int rb, a;
        if (!rst_n) begin model_reset(); return; end
        rb = 1 - m_sel;
        sw = m_full && !m_valid;
        if (we) begin
            if (!m_full) rm[m_sel][int'(waddr)] = wdata;
            else         m_ovr = 1;
        end
        m_rvalid = re && m_valid;
        if (m_rvalid) begin
            a = int'(raddr);
            m_mid = rm[rb][a];
            for (int e = 0; e < 2; e++) begin
                m_top[e] = row_at(rb, a - 1, e);
                m_bot[e] = row_at(rb, a + 1, e);
            end
        end
        if (sw) begin
            m_sel = 1 - m_sel; m_valid = 1; m_full = 0;
        end else begin
            if (wr_done && !m_full) m_full = 1;
            if (rd_done && m_valid) m_valid = 0;
        end
    endtask

    task automatic chk1(string n, logic got, logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", n, got, exp);
        end
    endtask

    task automatic chkr(string n, logic [DW-1:0] got, logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got lo=%h sum=%h want lo=%h sum=%h",
                     n, got[31:0], fold(got), exp[31:0], fold(exp));
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk1($sformatf("wr_ready[%0d]", d),   wr_ready[d],   logic'(!m_full));
            chk1($sformatf("img_valid[%0d]", d),  img_valid[d],  logic'(m_valid));
            chk1($sformatf("rvalid[%0d]", d),     rvalid[d],     logic'(m_rvalid));
            chk1($sformatf("rd_bank[%0d]", d),    rd_bank[d],    logic'(m_sel == 0));
            chk1($sformatf("wr_overrun[%0d]", d), wr_overrun[d], logic'(m_ovr));
            chkr($sformatf("rdata_top[%0d]", d),  rtop[d], m_top[d]);
            chkr($sformatf("rdata_mid[%0d]", d),  rmid[d], m_mid);
            chkr($sformatf("rdata_bot[%0d]", d),  rbot[d], m_bot[d]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic chk_reset_state(string tag);
        for (int d = 0; d < 2; d++) begin
            chk1({tag, " wr_ready"},   wr_ready[d],   1'b1);
            chk1({tag, " img_valid"},  img_valid[d],  1'b0);
            chk1({tag, " rvalid"},     rvalid[d],     1'b0);
            chk1({tag, " rd_bank"},    rd_bank[d],    1'b1);
            chk1({tag, " wr_overrun"}, wr_overrun[d], 1'b0);
            chkr({tag, " rdata_top"},  rtop[d], '0);
            chkr({tag, " rdata_mid"},  rmid[d], '0);
            chkr({tag, " rdata_bot"},  rbot[d], '0);
        end
    endtask

    task automatic load_image(int base);
        for (int k = 0; k < ROWS; k++) begin
            we = 1'b1; waddr = AW'(k); wdata = pat(k + base);
            cyc();
        end
        we = 1'b0;
    endtask

    initial begin
        we = 0; wr_done = 0; re = 0; rd_done = 0;
        waddr = '0; raddr = '0; wdata = '0;
        model_reset();

        // Reset state
        repeat (2) cyc();
        chk_reset_state("reset");
        rst_n = 1'b1;

        // First image, then hand-over
        load_image(1);
        wr_done = 1'b1; cyc(); wr_done = 1'b0;
        chk1("full wr_ready", wr_ready[0], 1'b0);
        chk1("full img_valid", img_valid[0], 1'b0);
        cyc();
        chk1("swap1 img_valid", img_valid[0], 1'b1);
        chk1("swap1 rd_bank", rd_bank[0], 1'b0);
        chk1("swap1 wr_ready", wr_ready[0], 1'b1);

        // Window table, issued back to back
        tbl[0] = '{7'd5,   5,   6,   7,   5,   7};
        tbl[1] = '{7'd0,   0,   1,   2,   1,   2};
        tbl[2] = '{7'd127, 127, 128, 0,   127, 128};
        tbl[3] = '{7'd64,  64,  65,  66,  64,  66};
        tbl[4] = '{7'd126, 126, 127, 128, 126, 128};
        tbl[5] = '{7'd1,   1,   2,   3,   1,   3};
        for (int i = 0; i < 6; i++) begin
            re = 1'b1; raddr = tbl[i].raddr;
            cyc();
            chk1($sformatf("tbl%0d rvalid", i), rvalid[0], 1'b1);
            chkr($sformatf("tbl%0d top0", i), rtop[0], pat(tbl[i].t0));
            chkr($sformatf("tbl%0d mid", i),  rmid[0], pat(tbl[i].m));
            chkr($sformatf("tbl%0d bot0", i), rbot[0], pat(tbl[i].b0));
            chkr($sformatf("tbl%0d top1", i), rtop[1], pat(tbl[i].t1));
            chkr($sformatf("tbl%0d bot1", i), rbot[1], pat(tbl[i].b1));
        end
        re = 1'b0; cyc();
        chk1("idle rvalid", rvalid[0], 1'b0);
        chkr("idle hold mid", rmid[0], pat(2));

        // Second image while the first is still being read
        load_image(1001);
        wr_done = 1'b1; cyc(); wr_done = 1'b0;
        cyc();
        chk1("noswap wr_ready", wr_ready[0], 1'b0);
        chk1("noswap rd_bank", rd_bank[0], 1'b0);
        chk1("noswap img_valid", img_valid[0], 1'b1);
        chk1("pre overrun", wr_overrun[0], 1'b0);
        we = 1'b1; waddr = 7'd3; wdata = pat(7777); cyc(); we = 1'b0;
        chk1("overrun", wr_overrun[0], 1'b1);

        // Read on the rd_done edge comes from the old bank; next re is ignored
        re = 1'b1; raddr = 7'd10; rd_done = 1'b1; cyc(); rd_done = 1'b0;
        chk1("rel rvalid", rvalid[0], 1'b1);
        chkr("rel top", rtop[0], pat(10));
        chkr("rel mid", rmid[0], pat(11));
        chkr("rel bot", rbot[0], pat(12));
        chk1("rel img_valid", img_valid[0], 1'b0);
        raddr = 7'd3; cyc(); re = 1'b0;
        chk1("swap2 rvalid", rvalid[0], 1'b0);
        chk1("swap2 rd_bank", rd_bank[0], 1'b1);
        chk1("swap2 img_valid", img_valid[0], 1'b1);
        chkr("swap2 hold mid", rmid[0], pat(11));
        re = 1'b1; raddr = 7'd19; cyc();
        chkr("img2 top", rtop[0], pat(1019));
        chkr("img2 mid", rmid[0], pat(1020));
        chkr("img2 bot", rbot[0], pat(1021));
        raddr = 7'd3; cyc(); re = 1'b0;
        chkr("dropped write", rmid[0], pat(1004));

        // Asynchronous reset in the middle of a read burst
        re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            raddr = AW'($urandom_range(0, ROWS-1));
            cyc();
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_state("async");
        cyc(); cyc();
        re = 1'b0; rst_n = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            we      = 1'($urandom_range(0, 1));
            waddr   = AW'($urandom_range(0, ROWS-1));
            wdata   = rand_row();
            wr_done = ($urandom_range(0, 15) == 0);
            rd_done = ($urandom_range(0, 11) == 0);
            re      = 1'($urandom_range(0, 1));
            raddr   = AW'($urandom_range(0, ROWS-1));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
